// File: rtl/seq_stim_player.sv
// seq_stim_player
//   Replays a programmable pattern of (MODE, DATA_IN) entries into the
//   sequence detector's IN_VALID/MODE/DATA_IN inputs. The run length,
//   repeat count and inter-pass gap are latched at START. Playback can be
//   stalled cycle-by-cycle with HOLD or aborted with STOP.
//
// Optional feature macro: SEQ_PLAYER_LOOP_EN
//   defined   : REPEAT=0 plays indefinitely until STOP; PASS_CNT wraps and
//               DONE never fires.
//   undefined : REPEAT=0 behaves as REPEAT=1.
//
// Ports
//   SYSCLK     clock, rising edge
//   RST_B      synchronous active-low reset
//   LOAD_EN    write {LOAD_MODE, LOAD_DATA} to pattern[LOAD_ADDR] (IDLE only)
//   LOAD_ADDR  pattern write address
//   LOAD_DATA  entry data value
//   LOAD_MODE  entry mode value
//   LEN        entries per pass (clamped to 2**ADDR_W), latched at START
//   REPEAT     number of passes, latched at START
//   GAP        idle cycles between passes, latched at START
//   START      begin playback (single-cycle pulse)
//   STOP       abort playback, highest priority
//   HOLD       stall playback this cycle
//   IN_VALID   data valid to the detector
//   MODE       mode to the detector
//   DATA_IN    data to the detector
//   BUSY       playback in progress (includes the DONE cycle)
//   DONE       one-cycle pulse on normal completion
//   PASS_CNT   completed passes in the current run
module seq_stim_player #(
    parameter int DATA_W = 4,
    parameter int MODE_W = 2,
    parameter int ADDR_W = 4
) (
    input  logic              SYSCLK,
    input  logic              RST_B,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic [MODE_W-1:0] LOAD_MODE,
    input  logic [ADDR_W:0]   LEN,
    input  logic [7:0]        REPEAT,
    input  logic [3:0]        GAP,
    input  logic              START,
    input  logic              STOP,
    input  logic              HOLD,
    output logic              IN_VALID,
    output logic [MODE_W-1:0] MODE,
    output logic [DATA_W-1:0] DATA_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic [7:0]        PASS_CNT
);

    localparam int ENTRY_W = MODE_W + DATA_W;
    localparam int DEPTH   = 2 ** ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ENTRY_W-1:0] pattern [DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q;
    logic [7:0]        rep_q;
    logic [3:0]        gap_q;
    logic [3:0]        gap_cnt;

    logic               start_ok;
    logic [ADDR_W:0]    len_clamped;
    logic [7:0]         rep_eff;
    logic [ADDR_W:0]    len_m1;
    logic               last_entry;
    logic               last_pass;
    logic [7:0]         pass_next;
    logic [ENTRY_W-1:0] entry;

    always_comb begin
        start_ok    = START && !STOP && (LEN != '0);
        len_clamped = (LEN > DEPTH_L) ? DEPTH_L : LEN;
`ifdef SEQ_PLAYER_LOOP_EN
        rep_eff     = REPEAT;
`else
        rep_eff     = (REPEAT == 8'd0) ? 8'd1 : REPEAT;
`endif
        len_m1      = len_q - LEN_ONE;
        last_entry  = ({1'b0, idx} == len_m1);
        pass_next   = PASS_CNT + 8'd1;
`ifdef SEQ_PLAYER_LOOP_EN
        // rep_q == 0 marks an endless run: never the final pass
        last_pass   = (rep_q != 8'd0) && (pass_next == rep_q);
`else
        last_pass   = (pass_next == rep_q);
`endif
        entry       = pattern[idx];
    end

    // Pattern memory is deliberately not reset; writes only land in IDLE.
    always_ff @(posedge SYSCLK) begin
        if (LOAD_EN && (state == S_IDLE)) begin
            pattern[LOAD_ADDR] <= {LOAD_MODE, LOAD_DATA};
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_B) begin
            state    <= S_IDLE;
            idx      <= '0;
            len_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            IN_VALID <= 1'b0;
            MODE     <= '0;
            DATA_IN  <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS_CNT <= '0;
        end else begin
            DONE <= 1'b0;
            if ((state != S_IDLE) && STOP) begin
                // Abort wins over HOLD, end-of-pass and FIN
                state    <= S_IDLE;
                IN_VALID <= 1'b0;
                BUSY     <= 1'b0;
                gap_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        IN_VALID <= 1'b0;
                        // BUSY stays high through the DONE cycle, drops here
                        BUSY     <= start_ok;
                        if (start_ok) begin
                            state    <= S_PLAY;
                            idx      <= '0;
                            PASS_CNT <= '0;
                            len_q    <= len_clamped;
                            rep_q    <= rep_eff;
                            gap_q    <= GAP;
                            gap_cnt  <= '0;
                        end
                    end
                    S_PLAY: begin
                        if (HOLD) begin
                            // MODE/DATA_IN keep their last value while stalled
                            IN_VALID <= 1'b0;
                        end else begin
                            IN_VALID <= 1'b1;
                            MODE     <= entry[ENTRY_W-1:DATA_W];
                            DATA_IN  <= entry[DATA_W-1:0];
                            if (last_entry) begin
                                idx      <= '0;
                                PASS_CNT <= pass_next;
                                if (last_pass) begin
                                    state <= S_FIN;
                                end else if (gap_q != 4'd0) begin
                                    state   <= S_GAP;
                                    gap_cnt <= gap_q;
                                end
                            end else begin
                                idx <= idx + IDX_ONE;
                            end
                        end
                    end
                    S_GAP: begin
                        IN_VALID <= 1'b0;
                        if (gap_cnt <= 4'd1) begin
                            state   <= S_PLAY;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    S_FIN: begin
                        IN_VALID <= 1'b0;
                        DONE     <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: begin
                        state    <= S_IDLE;
                        IN_VALID <= 1'b0;
                        BUSY     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_stim_player.sv
// tb_seq_stim_player
//   Directed bench for seq_stim_player with default parameters
//   (DATA_W=4, MODE_W=2, ADDR_W=4). Inputs are driven 1 time unit after the
//   rising edge and outputs are sampled at the same point, so each tick()
//   shows the registered result of exactly one clock edge.
module tb_seq_stim_player;

    logic       SYSCLK;
    logic       RST_B;
    logic       LOAD_EN;
    logic [3:0] LOAD_ADDR;
    logic [3:0] LOAD_DATA;
    logic [1:0] LOAD_MODE;
    logic [4:0] LEN;
    logic [7:0] REPEAT;
    logic [3:0] GAP;
    logic       START;
    logic       STOP;
    logic       HOLD;
    logic       IN_VALID;
    logic [1:0] MODE;
    logic [3:0] DATA_IN;
    logic       BUSY;
    logic       DONE;
    logic [7:0] PASS_CNT;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_data [16];
    logic [1:0] exp_mode [16];

    seq_stim_player #(.DATA_W(4), .MODE_W(2), .ADDR_W(4)) dut (
        .SYSCLK    (SYSCLK),
        .RST_B     (RST_B),
        .LOAD_EN   (LOAD_EN),
        .LOAD_ADDR (LOAD_ADDR),
        .LOAD_DATA (LOAD_DATA),
        .LOAD_MODE (LOAD_MODE),
        .LEN       (LEN),
        .REPEAT    (REPEAT),
        .GAP       (GAP),
        .START     (START),
        .STOP      (STOP),
        .HOLD      (HOLD),
        .IN_VALID  (IN_VALID),
        .MODE      (MODE),
        .DATA_IN   (DATA_IN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .PASS_CNT  (PASS_CNT)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic load_entry(input logic [3:0] a, input logic [1:0] m, input logic [3:0] d);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = a;
        LOAD_MODE = m;
        LOAD_DATA = d;
        tick();
        LOAD_EN   = 1'b0;
        exp_mode[a] = m;
        exp_data[a] = d;
    endtask

    task automatic do_start(input logic [4:0] l, input logic [7:0] r, input logic [3:0] g);
        LEN    = l;
        REPEAT = r;
        GAP    = g;
        START  = 1'b1;
        tick();
        START  = 1'b0;
    endtask

    task automatic test_reset();
        RST_B = 1'b0;
        repeat (3) tick();
        checks++;
        if ({IN_VALID, MODE, DATA_IN, BUSY, DONE, PASS_CNT} !== 17'd0) begin
            errors++;
            $display("FAIL reset_in got=%h exp=0", {IN_VALID, MODE, DATA_IN, BUSY, DONE, PASS_CNT});
        end
        RST_B = 1'b1;
        repeat (3) tick();
        checks++;
        if ({IN_VALID, MODE, DATA_IN, BUSY, DONE, PASS_CNT} !== 17'd0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=0", {IN_VALID, MODE, DATA_IN, BUSY, DONE, PASS_CNT});
        end
    endtask

    task automatic test_single_pass();
        logic [7:0] got, exp;
        load_entry(4'd0, 2'd1, 4'h3);
        load_entry(4'd1, 2'd1, 4'h5);
        load_entry(4'd2, 2'd1, 4'hA);
        load_entry(4'd3, 2'd1, 4'hC);
        do_start(5'd4, 8'd1, 4'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            got = {IN_VALID, DONE, MODE, DATA_IN};
            exp = {1'b1, 1'b0, exp_mode[k], exp_data[k]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_entry k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 0) begin
                checks++;
                if (BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy got=%b exp=1", BUSY);
                end
            end
        end
        tick();
        checks++;
        if ({IN_VALID, DONE, BUSY, PASS_CNT} !== {1'b0, 1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL single_done got v=%b d=%b b=%b p=%0d exp v=0 d=1 b=1 p=1", IN_VALID, DONE, BUSY, PASS_CNT);
        end
        tick();
        checks++;
        if ({IN_VALID, DONE, BUSY, PASS_CNT} !== {1'b0, 1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL single_after got v=%b d=%b b=%b p=%0d exp v=0 d=0 b=0 p=1", IN_VALID, DONE, BUSY, PASS_CNT);
        end
    endtask

    task automatic test_repeat_gap();
        logic [7:0] got, exp;
        do_start(5'd4, 8'd3, 4'd2);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                got = {IN_VALID, DONE, MODE, DATA_IN};
                exp = {1'b1, 1'b0, exp_mode[k], exp_data[k]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL repeat_entry p=%0d k=%0d got=%h exp=%h", p, k, got, exp);
                end
            end
            checks++;
            if (PASS_CNT !== 8'(p + 1)) begin
                errors++;
                $display("FAIL repeat_pass_cnt p=%0d got=%0d exp=%0d", p, PASS_CNT, p + 1);
            end
            if (p < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    checks++;
                    if ({IN_VALID, DONE, BUSY} !== 3'b001) begin
                        errors++;
                        $display("FAIL repeat_gap p=%0d g=%0d got=%b exp=001", p, g, {IN_VALID, DONE, BUSY});
                    end
                end
            end
        end
        tick();
        checks++;
        if ({IN_VALID, DONE, PASS_CNT} !== {1'b0, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL repeat_done got v=%b d=%b p=%0d exp v=0 d=1 p=3", IN_VALID, DONE, PASS_CNT);
        end
        tick();
        checks++;
        if ({DONE, BUSY, PASS_CNT} !== {1'b0, 1'b0, 8'd3}) begin
            errors++;
            $display("FAIL repeat_idle got d=%b b=%b p=%0d exp d=0 b=0 p=3", DONE, BUSY, PASS_CNT);
        end
    endtask

    task automatic test_hold();
        logic [7:0] got, exp;
        do_start(5'd4, 8'd1, 4'd0);
        tick();
        checks++;
        if ({IN_VALID, DATA_IN} !== {1'b1, 4'h3}) begin
            errors++;
            $display("FAIL hold_first got=%h exp=13", {IN_VALID, DATA_IN});
        end
        HOLD = 1'b1;
        for (int h = 0; h < 2; h++) begin
            tick();
            checks++;
            if ({IN_VALID, DONE, DATA_IN} !== {1'b0, 1'b0, 4'h3}) begin
                errors++;
                $display("FAIL hold_stall h=%0d got=%h exp=03", h, {IN_VALID, DONE, DATA_IN});
            end
        end
        HOLD = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            got = {IN_VALID, DONE, MODE, DATA_IN};
            exp = {1'b1, 1'b0, exp_mode[k], exp_data[k]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_resume k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        tick();
        checks++;
        if ({IN_VALID, DONE} !== 2'b01) begin
            errors++;
            $display("FAIL hold_done got=%b exp=01", {IN_VALID, DONE});
        end
        tick();
    endtask

    task automatic test_abort();
        do_start(5'd4, 8'd2, 4'd0);
        repeat (3) tick();
        checks++;
        if ({IN_VALID, DATA_IN} !== {1'b1, 4'hA}) begin
            errors++;
            $display("FAIL abort_third got=%h exp=1a", {IN_VALID, DATA_IN});
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        checks++;
        if ({IN_VALID, DONE, BUSY} !== 3'b000) begin
            errors++;
            $display("FAIL abort_stop got=%b exp=000", {IN_VALID, DONE, BUSY});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({IN_VALID, DONE, BUSY} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet i=%0d got=%b exp=000", i, {IN_VALID, DONE, BUSY});
            end
        end
        // START together with STOP, then START with LEN=0: both ignored
        STOP = 1'b1;
        do_start(5'd4, 8'd1, 4'd0);
        STOP = 1'b0;
        do_start(5'd0, 8'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({IN_VALID, DONE, BUSY} !== 3'b000) begin
                errors++;
                $display("FAIL ignore_start i=%0d got=%b exp=000", i, {IN_VALID, DONE, BUSY});
            end
        end
        // reset mid-run aborts without DONE
        do_start(5'd4, 8'd1, 4'd0);
        repeat (2) tick();
        RST_B = 1'b0;
        tick();
        RST_B = 1'b1;
        checks++;
        if ({IN_VALID, DONE, BUSY, PASS_CNT} !== 11'd0) begin
            errors++;
            $display("FAIL abort_reset got=%h exp=0", {IN_VALID, DONE, BUSY, PASS_CNT});
        end
        tick();
        checks++;
        if ({IN_VALID, DONE, BUSY} !== 3'b000) begin
            errors++;
            $display("FAIL abort_reset_after got=%b exp=000", {IN_VALID, DONE, BUSY});
        end
    endtask

    task automatic test_load_busy();
        do_start(5'd4, 8'd1, 4'd0);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 4'd1;
        LOAD_MODE = 2'd2;
        LOAD_DATA = 4'hF;
        tick();
        LOAD_EN   = 1'b0;
        repeat (5) tick();
        do_start(5'd4, 8'd1, 4'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({IN_VALID, MODE, DATA_IN} !== {1'b1, exp_mode[k], exp_data[k]}) begin
                errors++;
                $display("FAIL load_busy k=%0d got=%h exp=%h", k, {IN_VALID, MODE, DATA_IN},
                         {1'b1, exp_mode[k], exp_data[k]});
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_clamp();
        logic [7:0] got, exp;
        for (int a = 4; a < 16; a++) begin
            load_entry(4'(a), 2'(a), 4'(15 - a));
        end
        do_start(5'd20, 8'd1, 4'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            got = {IN_VALID, DONE, MODE, DATA_IN};
            exp = {1'b1, 1'b0, exp_mode[k], exp_data[k]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clamp_entry k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        tick();
        checks++;
        if ({IN_VALID, DONE, PASS_CNT} !== {1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL clamp_done got v=%b d=%b p=%0d exp v=0 d=1 p=1", IN_VALID, DONE, PASS_CNT);
        end
        tick();
    endtask

    task automatic test_loop();
        do_start(5'd2, 8'd0, 4'd0);
`ifdef SEQ_PLAYER_LOOP_EN
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({IN_VALID, DONE, DATA_IN} !== {1'b1, 1'b0, exp_data[k % 2]}) begin
                errors++;
                $display("FAIL loop_entry k=%0d got=%h exp=%h", k, {IN_VALID, DONE, DATA_IN},
                         {1'b1, 1'b0, exp_data[k % 2]});
            end
        end
        checks++;
        if (PASS_CNT !== 8'd5) begin
            errors++;
            $display("FAIL loop_pass_cnt got=%0d exp=5", PASS_CNT);
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        checks++;
        if ({IN_VALID, DONE, BUSY} !== 3'b000) begin
            errors++;
            $display("FAIL loop_stop got=%b exp=000", {IN_VALID, DONE, BUSY});
        end
`else
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({IN_VALID, DONE, DATA_IN} !== {1'b1, 1'b0, exp_data[k]}) begin
                errors++;
                $display("FAIL loop_entry k=%0d got=%h exp=%h", k, {IN_VALID, DONE, DATA_IN},
                         {1'b1, 1'b0, exp_data[k]});
            end
        end
        tick();
        checks++;
        if ({IN_VALID, DONE, PASS_CNT} !== {1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL loop_done got v=%b d=%b p=%0d exp v=0 d=1 p=1", IN_VALID, DONE, PASS_CNT);
        end
`endif
        tick();
    endtask

    initial begin
        RST_B     = 1'b0;
        LOAD_EN   = 1'b0;
        LOAD_ADDR = '0;
        LOAD_DATA = '0;
        LOAD_MODE = '0;
        LEN       = '0;
        REPEAT    = '0;
        GAP       = '0;
        START     = 1'b0;
        STOP      = 1'b0;
        HOLD      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_data[i] = '0;
            exp_mode[i] = '0;
        end
        test_reset();
        test_single_pass();
        test_repeat_gap();
        test_hold();
        test_abort();
        test_load_busy();
        test_clamp();
        test_loop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
